// File: rtl/motor_bridge_driver.sv
`default_nettype none
// ============================================================================
// Module      : motor_bridge_driver
// Description : H-bridge gate driver with break-before-make dead time and
//               PWM on the high-side switch of the active bridge leg.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_bridge_driver #(
    parameter logic [15:0] DEAD_TIME = 16'd1000,
    parameter logic [7:0]  PWM_DIV   = 8'd0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MOTOR_DIR,
    input  logic       MOTOR_EN,
    input  logic [7:0] DUTY,
    output logic       GATE_AH,
    output logic       GATE_AL,
    output logic       GATE_BH,
    output logic       GATE_BL,
    output logic [1:0] STATE
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FWD  = 2'd1;
    localparam logic [1:0] c_ST_REV  = 2'd2;
    localparam logic [1:0] c_ST_DEAD = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_dead_cnt;
    logic [1:0]  r_dead_req;   // request seen on the previous DEAD cycle
    logic [7:0]  r_pwm_cnt;
    logic [7:0]  r_pre;
    logic [7:0]  r_duty;
    logic        r_gate_ah;
    logic        r_gate_al;
    logic        r_gate_bh;
    logic        r_gate_bl;

    logic [1:0]  w_req;
    logic [1:0]  w_nxt_state;
    logic [15:0] w_nxt_dead;
    logic [1:0]  w_nxt_dead_req;
    logic [7:0]  w_nxt_cnt;
    logic [7:0]  w_nxt_pre;
    logic [7:0]  w_nxt_duty;
    logic        w_pwm_on;

    // Decode the requested operating mode from enable and direction
    always_comb begin
        if (!MOTOR_EN) begin
            w_req = c_ST_IDLE;
        end else if (MOTOR_DIR) begin
            w_req = c_ST_FWD;
        end else begin
            w_req = c_ST_REV;
        end
    end

    // Next-state, dead-time and PWM counter logic; counters sit at 0 unless driving
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_dead     = r_dead_cnt;
        w_nxt_dead_req = r_dead_req;
        w_nxt_cnt      = 8'd0;
        w_nxt_pre      = 8'd0;
        w_nxt_duty     = r_duty;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req != c_ST_IDLE) begin
                    w_nxt_state = w_req;
                    w_nxt_duty  = DUTY;
                end
            end
            c_ST_FWD, c_ST_REV: begin
                if (w_req != r_state) begin
                    w_nxt_state    = c_ST_DEAD;
                    w_nxt_dead     = DEAD_TIME;
                    w_nxt_dead_req = w_req;
                end else if (r_pre == PWM_DIV) begin
                    w_nxt_cnt = r_pwm_cnt + 8'd1;
                    // Duty only takes effect at a period boundary
                    if (r_pwm_cnt == 8'hFF) begin
                        w_nxt_duty = DUTY;
                    end
                end else begin
                    w_nxt_pre = r_pre + 8'd1;
                    w_nxt_cnt = r_pwm_cnt;
                end
            end
            default: begin
                w_nxt_dead_req = w_req;
                if (w_req == c_ST_IDLE) begin
                    // Coasting needs no break-before-make wait
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_dead  = 16'd0;
                end else if ((r_dead_req != c_ST_IDLE) && (w_req != r_dead_req)) begin
                    // Direction flipped while waiting: restart the full dead time
                    w_nxt_dead = DEAD_TIME;
                end else if (r_dead_cnt == 16'd0) begin
                    w_nxt_state = w_req;
                    w_nxt_duty  = DUTY;
                end else begin
                    w_nxt_dead = r_dead_cnt - 16'd1;
                end
            end
        endcase
    end

    // PWM compare on the next counter value so the gate register lines up with the counter
    assign w_pwm_on = (w_nxt_cnt < w_nxt_duty);

    // State, counters and gate registers; reset drops every gate at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= c_ST_IDLE;
            r_dead_cnt <= 16'd0;
            r_dead_req <= c_ST_IDLE;
            r_pwm_cnt  <= 8'd0;
            r_pre      <= 8'd0;
            r_duty     <= 8'd0;
            r_gate_ah  <= 1'b0;
            r_gate_al  <= 1'b0;
            r_gate_bh  <= 1'b0;
            r_gate_bl  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_dead_cnt <= w_nxt_dead;
            r_dead_req <= w_nxt_dead_req;
            r_pwm_cnt  <= w_nxt_cnt;
            r_pre      <= w_nxt_pre;
            r_duty     <= w_nxt_duty;
            r_gate_ah  <= (w_nxt_state == c_ST_FWD) && w_pwm_on;
            r_gate_bl  <= (w_nxt_state == c_ST_FWD);
            r_gate_bh  <= (w_nxt_state == c_ST_REV) && w_pwm_on;
            r_gate_al  <= (w_nxt_state == c_ST_REV);
        end
    end

    assign STATE   = r_state;
    assign GATE_AH = r_gate_ah;
    assign GATE_AL = r_gate_al;
    assign GATE_BH = r_gate_bh;
    assign GATE_BL = r_gate_bl;

endmodule
`default_nettype wire

// File: tb/tb_motor_bridge_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_bridge_driver
// Description : Directed vector table plus hand sequences for dead-time
//               reload, duty latching and asynchronous reset; a monitor
//               watches for shoot-through and short FWD/REV gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_bridge_driver;

    logic       CLK;
    logic       RST;
    logic       MOTOR_DIR;
    logic       MOTOR_EN;
    logic [7:0] DUTY;
    logic       GATE_AH;
    logic       GATE_AL;
    logic       GATE_BH;
    logic       GATE_BL;
    logic [1:0] STATE;

    int errors = 0;
    int checks = 0;

    motor_bridge_driver #(
        .DEAD_TIME (16'd4),
        .PWM_DIV   (8'd0)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MOTOR_DIR (MOTOR_DIR),
        .MOTOR_EN  (MOTOR_EN),
        .DUTY      (DUTY),
        .GATE_AH   (GATE_AH),
        .GATE_AL   (GATE_AL),
        .GATE_BH   (GATE_BH),
        .GATE_BL   (GATE_BL),
        .STATE     (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic       dir;
        logic [7:0] duty;
        logic [1:0] st;
        logic       ah;
        logic       al;
        logic       bh;
        logic       bl;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {STATE, GATE_AH, GATE_AL, GATE_BH, GATE_BL};
    endfunction

    // Safety monitor: no leg shoot-through, and direct FWD<->REV needs 5 off cycles
    logic [1:0] last_drive = 2'd0;
    int         off_cnt    = 0;
    always @(negedge CLK) begin
        checks++;
        if ((GATE_AH && GATE_AL) || (GATE_BH && GATE_BL)) begin
            errors++;
            $display("FAIL shoot_through: gates ah=%b al=%b bh=%b bl=%b required no leg overlap",
                     GATE_AH, GATE_AL, GATE_BH, GATE_BL);
        end
        if (STATE == 2'd1 || STATE == 2'd2) begin
            if (last_drive != 2'd0 && last_drive != STATE) begin
                checks++;
                if (off_cnt < 5) begin
                    errors++;
                    $display("FAIL dead_gap: got %0d off cycles required >= 5", off_cnt);
                end
            end
            last_drive = STATE;
            off_cnt    = 0;
        end else if (STATE == 2'd0) begin
            last_drive = 2'd0;
            off_cnt    = 0;
        end else begin
            off_cnt++;
        end
    end

    int ah_count;

    initial begin
        //           en    dir   duty   st     ah    al    bh    bl
        vecs[0]  = '{1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};

        RST       = 1'b1;
        MOTOR_EN  = 1'b0;
        MOTOR_DIR = 1'b0;
        DUTY      = 8'd0;
        #2;
        chk("reset_outputs", {26'd0, outs()}, {26'd0, 2'd0, 4'b0000});
        @(negedge CLK);
        RST = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 17; i++) begin
            MOTOR_EN  = vecs[i].en;
            MOTOR_DIR = vecs[i].dir;
            DUTY      = vecs[i].duty;
            step();
            chk($sformatf("vec%0d", i), {26'd0, outs()},
                {26'd0, vecs[i].st, vecs[i].ah, vecs[i].al, vecs[i].bh, vecs[i].bl});
        end

        // Direction flips back while DEAD at count 2: full reload
        MOTOR_EN = 1'b1; MOTOR_DIR = 1'b1; DUTY = 8'd10;
        step();
        chk("reload_pre_fwd", {30'd0, STATE}, 32'd1);
        MOTOR_DIR = 1'b0;
        step();
        step();
        step();
        chk("reload_dead_cnt2", {30'd0, STATE}, 32'd3);
        MOTOR_DIR = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("reload_dead%0d", k), {26'd0, outs()}, {26'd0, 2'd3, 4'b0000});
        end
        step();
        chk("reload_exit_fwd", {26'd0, outs()}, {26'd0, 2'd1, 4'b1001});

        // Mid-period duty change applies from the next period only
        MOTOR_EN = 1'b0;
        step();
        step();
        chk("duty_idle", {30'd0, STATE}, 32'd0);
        MOTOR_EN = 1'b1; MOTOR_DIR = 1'b1; DUTY = 8'd64;
        ah_count = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (GATE_AH) ah_count++;
            if (i == 10) DUTY = 8'd200;
        end
        chk("duty_period1_on", ah_count, 32'd64);
        ah_count = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (GATE_AH) ah_count++;
        end
        chk("duty_period2_on", ah_count, 32'd200);

        // Asynchronous reset in REV drops gates before the next edge
        MOTOR_EN = 1'b0;
        step();
        step();
        MOTOR_EN = 1'b1; MOTOR_DIR = 1'b0; DUTY = 8'd128;
        step();
        chk("rev_entry", {26'd0, outs()}, {26'd0, 2'd2, 4'b0110});
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset", {26'd0, outs()}, {26'd0, 2'd0, 4'b0000});
        #2;
        RST = 1'b0;
        step();
        chk("post_reset_rev", {26'd0, outs()}, {26'd0, 2'd2, 4'b0110});

        // Random traffic for the safety monitor
        for (int i = 0; i < 3000; i++) begin
            MOTOR_EN = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) MOTOR_DIR = ~MOTOR_DIR;
            DUTY = 8'($urandom_range(0, 255));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
